// File: rtl/life_pkg.sv
// Shared types and widths for the ship life bookkeeping stage.
// The state enum is shared so the top and any debug logic agree on the encoding.
package life_pkg;

  localparam int DEAD_W      = 4;
  localparam int FRAME_CNT_W = 10;
  localparam int BLINK_CNT_W = 6;

  typedef enum logic [1:0] {
    ST_ALIVE = 2'd0,
    ST_INVUL = 2'd1,
    ST_OVER  = 2'd2
  } life_state_t;

  // Saturating increment so the lost-life count can never pass the limit.
  function automatic logic [DEAD_W-1:0] sat_inc(input logic [DEAD_W-1:0] v,
                                                input logic [DEAD_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage

// File: rtl/life_ctl_vsync_edge.sv
// Rising-edge detector on vertical sync; one frame tick per new frame.
// Only the history register is clocked; the tick itself is combinational from it.
module vsync_edge (
  input  logic pclk,
  input  logic rst,
  input  logic vsync_in,
  output logic frame_tick
);

  logic r_vsync_q;

  always_ff @(posedge pclk) begin
    if (rst) r_vsync_q <= 1'b0;
    else     r_vsync_q <= vsync_in;
  end

  assign frame_tick = vsync_in & ~r_vsync_q;

endmodule

// File: rtl/life_ctl.sv
// Ship life bookkeeping: counts accepted hits, runs the blinking invulnerability
// window after each non-final loss, and flags game over when lives run out.
module life_ctl
  import life_pkg::*;
#(
  parameter int LIVES        = 3,
  parameter int INVUL_FRAMES = 120,
  parameter int BLINK_FRAMES = 8
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              vsync_in,
  input  logic              hit,
  input  logic              new_game,
  output logic [DEAD_W-1:0] dead_count,
  output logic              life_lost,
  output logic              invulnerable,
  output logic              ship_visible,
  output logic              game_over
);

  localparam logic [DEAD_W-1:0]      LP_LIVES = DEAD_W'(LIVES);
  localparam logic [FRAME_CNT_W-1:0] LP_INVUL = FRAME_CNT_W'(INVUL_FRAMES);
  localparam logic [BLINK_CNT_W-1:0] LP_BLINK = BLINK_CNT_W'(BLINK_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] LP_F_ONE = FRAME_CNT_W'(1);
  localparam logic [BLINK_CNT_W-1:0] LP_B_ONE = BLINK_CNT_W'(1);

  life_state_t            r_state, w_state_nxt;
  logic [FRAME_CNT_W-1:0] r_frame_cnt, w_frame_nxt;
  logic [BLINK_CNT_W-1:0] r_blink_cnt, w_blink_nxt;
  logic [DEAD_W-1:0]      r_dead, w_dead_nxt;
  logic                   r_life_lost, w_lost_nxt;
  logic                   r_visible, w_visible_nxt;
  logic                   r_invul, r_over;
  logic                   w_frame_tick;

  vsync_edge u_vsync_edge (
    .pclk       (pclk),
    .rst        (rst),
    .vsync_in   (vsync_in),
    .frame_tick (w_frame_tick)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_frame_nxt   = r_frame_cnt;
    w_blink_nxt   = r_blink_cnt;
    w_dead_nxt    = r_dead;
    w_lost_nxt    = 1'b0;
    w_visible_nxt = r_visible;

    if (new_game) begin
      w_state_nxt   = ST_ALIVE;
      w_frame_nxt   = '0;
      w_blink_nxt   = '0;
      w_dead_nxt    = '0;
      w_visible_nxt = 1'b1;
    end else begin
      unique case (r_state)
        // A hit in ALIVE wins over a coincident frame tick; counters load fresh.
        ST_ALIVE: begin
          w_visible_nxt = 1'b1;
          if (hit) begin
            w_lost_nxt    = 1'b1;
            w_dead_nxt    = sat_inc(r_dead, LP_LIVES);
            w_visible_nxt = 1'b0;
            if (w_dead_nxt == LP_LIVES) begin
              w_state_nxt = ST_OVER;
              w_frame_nxt = '0;
              w_blink_nxt = '0;
            end else begin
              w_state_nxt = ST_INVUL;
              w_frame_nxt = LP_INVUL;
              w_blink_nxt = LP_BLINK;
            end
          end
        end
        ST_INVUL: begin
          if (w_frame_tick) begin
            if (r_frame_cnt <= LP_F_ONE) begin
              w_state_nxt   = ST_ALIVE;
              w_frame_nxt   = '0;
              w_blink_nxt   = '0;
              w_visible_nxt = 1'b1;
            end else begin
              w_frame_nxt = r_frame_cnt - 1'b1;
              // Reload on the tick that would take the blink count to zero.
              if (r_blink_cnt <= LP_B_ONE) begin
                w_blink_nxt   = LP_BLINK;
                w_visible_nxt = ~r_visible;
              end else begin
                w_blink_nxt = r_blink_cnt - 1'b1;
              end
            end
          end
        end
        ST_OVER: begin
          w_visible_nxt = 1'b0;
          w_dead_nxt    = LP_LIVES;
        end
        default: begin
          w_state_nxt   = ST_ALIVE;
          w_frame_nxt   = '0;
          w_blink_nxt   = '0;
          w_visible_nxt = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state     <= ST_ALIVE;
      r_frame_cnt <= '0;
      r_blink_cnt <= '0;
      r_dead      <= '0;
      r_life_lost <= 1'b0;
      r_visible   <= 1'b1;
      r_invul     <= 1'b0;
      r_over      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_frame_cnt <= w_frame_nxt;
      r_blink_cnt <= w_blink_nxt;
      r_dead      <= w_dead_nxt;
      r_life_lost <= w_lost_nxt;
      r_visible   <= w_visible_nxt;
      r_invul     <= (w_state_nxt == ST_INVUL);
      r_over      <= (w_state_nxt == ST_OVER);
    end
  end

  assign dead_count   = r_dead;
  assign life_lost    = r_life_lost;
  assign invulnerable = r_invul;
  assign ship_visible = r_visible;
  assign game_over    = r_over;

endmodule
